// File: rtl/edge_frame_sequencer_pkg.sv
// Shared types and constants for the edge-detection frame sequencer.
package edge_pkg;
    typedef enum logic [1:0] {IDLE, FETCH, DRAIN, WAIT_SWAP} seq_state_e;

    localparam int DEF_WIDTH = 160;
    localparam int DEF_DEPTH = 120;
    localparam int PIX_W     = 8;
endpackage

// File: rtl/edge_frame_sequencer_if.sv
// Sequencer-side bundle: image memory read port, pixel stream to Sobel,
// edge results back from Sobel, and the framebuffer write port.
interface edge_frame_sequencer_if #(parameter int AW = 15);
    import edge_pkg::*;

    logic             img_rd_en;
    logic [AW-1:0]    img_rd_addr;
    logic [PIX_W-1:0] img_rd_data;
    logic             pix_valid;
    logic [PIX_W-1:0] pix_data;
    logic             pix_ready;
    logic [PIX_W-1:0] sobel_threshold;
    logic             edge_valid;
    logic             edge_bit;
    logic             fb_we;
    logic [AW:0]      fb_addr;
    logic             fb_wdata;

    modport master (
        output img_rd_en, img_rd_addr, pix_valid, pix_data, sobel_threshold,
               fb_we, fb_addr, fb_wdata,
        input  img_rd_data, pix_ready, edge_valid, edge_bit
    );

    modport slave (
        input  img_rd_en, img_rd_addr, pix_valid, pix_data, sobel_threshold,
               fb_we, fb_addr, fb_wdata,
        output img_rd_data, pix_ready, edge_valid, edge_bit
    );
endinterface

// File: rtl/edge_frame_sequencer_seq_skid_fifo.sv
// Two-entry skid FIFO between the 1-cycle image memory and the Sobel input.
module seq_skid_fifo
    import edge_pkg::*;
#(
    parameter int W = PIX_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic [W-1:0] din,
    input  logic         pop,
    input  logic         flush,
    output logic [W-1:0] dout,
    output logic [1:0]   count
);
    logic [W-1:0] mem [2];
    logic         wr_ptr, rd_ptr;
    logic         do_push, do_pop;

    assign do_pop  = pop && (count != 2'd0);
    assign do_push = push && ((count != 2'd2) || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem[0] <= '0;
            mem[1] <= '0;
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else if (flush) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) rd_ptr <= ~rd_ptr;
            count <= count + {1'b0, do_push} - {1'b0, do_pop};
        end
    end
endmodule

// File: rtl/edge_frame_sequencer.sv
// Frame controller: streams the image into Sobel, writes edge bits into the
// back framebuffer half, and swaps halves at the vsync after the frame ends.
module edge_frame_sequencer
    import edge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  continuous,
    input  logic                  abort,
    input  logic [PIX_W-1:0]      threshold,
    input  logic                  vsync_pulse,
    edge_frame_sequencer_if.master bus,
    output logic                  disp_buf,
    output logic                  busy,
    output logic                  frame_done,
    output logic [15:0]           frame_count
);
    localparam int NPIX = WIDTH * DEPTH;
    localparam int AW   = $clog2(NPIX);
    localparam logic [AW-1:0] NPIX_A = AW'(NPIX);
    localparam logic [AW-1:0] LAST   = AW'(NPIX - 1);

    seq_state_e       state;
    logic [AW-1:0]    rd_idx, out_idx, wr_idx;
    logic [PIX_W-1:0] thr_q;
    logic             rd_pending;
    logic             fb_we_q, fb_wdata_q;
    logic [AW:0]      fb_addr_q;
    logic [1:0]       fifo_count;
    logic [PIX_W-1:0] fifo_head;
    logic             in_frame, pix_valid, pop, issue;
    logic             take_result, last_result, do_swap;

    assign in_frame  = (state == FETCH) || (state == DRAIN);
    assign pix_valid = (state == FETCH) && (fifo_count != 2'd0);
    assign pop       = pix_valid && bus.pix_ready;

    // A new read needs a slot after this cycle's pop, counting the read whose
    // data lands in the FIFO next cycle.
    assign issue = (state == FETCH) && !abort && (rd_idx < NPIX_A) &&
                   (({1'b0, fifo_count} + {2'b0, rd_pending}) < (3'd2 + {2'b0, pop}));

    assign take_result = in_frame && bus.edge_valid && !abort;
    assign last_result = take_result && (wr_idx == LAST);
    // A vsync coinciding with the final result already counts for the swap.
    assign do_swap     = !abort && vsync_pulse && ((state == WAIT_SWAP) || last_result);

    seq_skid_fifo #(.W(PIX_W)) u_skid (
        .clk   (clk),
        .rst   (rst),
        .push  (rd_pending && (state == FETCH)),
        .din   (bus.img_rd_data),
        .pop   (pop),
        .flush (abort),
        .dout  (fifo_head),
        .count (fifo_count)
    );

    assign bus.img_rd_en       = issue;
    assign bus.img_rd_addr     = issue ? rd_idx : '0;
    assign bus.pix_valid       = pix_valid;
    assign bus.pix_data        = pix_valid ? fifo_head : '0;
    assign bus.sobel_threshold = thr_q;
    assign bus.fb_we           = fb_we_q;
    assign bus.fb_addr         = fb_addr_q;
    assign bus.fb_wdata        = fb_wdata_q;
    assign busy                = (state != IDLE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            rd_idx      <= '0;
            out_idx     <= '0;
            wr_idx      <= '0;
            thr_q       <= '0;
            rd_pending  <= 1'b0;
            fb_we_q     <= 1'b0;
            fb_addr_q   <= '0;
            fb_wdata_q  <= 1'b0;
            disp_buf    <= 1'b0;
            frame_done  <= 1'b0;
            frame_count <= '0;
        end else begin
            rd_pending <= issue;
            fb_we_q    <= take_result;
            frame_done <= do_swap;
            if (issue) rd_idx <= rd_idx + AW'(1);
            if (pop)   out_idx <= out_idx + AW'(1);
            if (take_result) begin
                fb_addr_q  <= {~disp_buf, wr_idx};
                fb_wdata_q <= bus.edge_bit;
                wr_idx     <= wr_idx + AW'(1);
            end
            case (state)
                IDLE: if (start) begin
                    thr_q   <= threshold;
                    rd_idx  <= '0;
                    out_idx <= '0;
                    wr_idx  <= '0;
                    state   <= FETCH;
                end
                FETCH: if (pop && (out_idx == LAST)) state <= DRAIN;
                default: ;
            endcase
            if (last_result) state <= WAIT_SWAP;
            if (do_swap) begin
                disp_buf    <= ~disp_buf;
                frame_count <= frame_count + 16'd1;
                if (continuous) begin
                    thr_q   <= threshold;
                    rd_idx  <= '0;
                    out_idx <= '0;
                    wr_idx  <= '0;
                    state   <= FETCH;
                end else begin
                    state <= IDLE;
                end
            end
            if (abort) state <= IDLE;
        end
    end
endmodule

// File: tb/tb_edge_frame_sequencer.sv
// Directed/randomized bench for edge_frame_sequencer on a 4x3 image with a
// 3-cycle Sobel model and a frame-level reference of expected memory contents.
module tb_edge_frame_sequencer;
    import edge_pkg::*;

    localparam int W    = 4;
    localparam int D    = 3;
    localparam int NPIX = W * D;
    localparam int AW   = $clog2(NPIX);

    logic        clk = 1'b0, rst = 1'b1;
    logic        start = 1'b0, continuous = 1'b0, abort = 1'b0, vsync_pulse = 1'b0;
    logic [7:0]  threshold = 8'd0;
    logic        disp_buf, busy, frame_done;
    logic [15:0] frame_count;

    edge_frame_sequencer_if #(.AW(AW)) bus();

    edge_frame_sequencer #(.WIDTH(W), .DEPTH(D)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .continuous  (continuous),
        .abort       (abort),
        .threshold   (threshold),
        .vsync_pulse (vsync_pulse),
        .bus         (bus),
        .disp_buf    (disp_buf),
        .busy        (busy),
        .frame_done  (frame_done),
        .frame_count (frame_count)
    );

    always #5 clk = ~clk;

    int         checks = 0, errors = 0;
    logic [7:0] mem [NPIX];
    int         ready_mode = 0, cyc_n = 0;
    int         em_cnt = 0, done_cnt = 0, swaps = 0, fc_m = 0;
    logic       disp_m = 1'b0;
    int         rd_q[$], acc_q[$], wr_q[$];
    logic [1:0] sv;
    logic [7:0] sd0, sd1;
    logic       prev_stall = 1'b0;
    logic [7:0] prev_pix = 8'd0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Image memory: data one cycle after the strobe, junk otherwise.
    always @(posedge clk)
        bus.img_rd_data <= bus.img_rd_en ? mem[bus.img_rd_addr] : 8'($urandom);

    // Sobel stand-in: edge = pixel above the latched threshold, 3-cycle latency.
    always @(posedge clk) begin
        if (rst) begin
            sv             <= 2'b00;
            bus.edge_valid <= 1'b0;
            bus.edge_bit   <= 1'b0;
        end else begin
            sv             <= {sv[0], bus.pix_valid && bus.pix_ready};
            sd0            <= bus.pix_data;
            sd1            <= sd0;
            bus.edge_valid <= sv[1];
            bus.edge_bit   <= sd1 > bus.sobel_threshold;
            if (sv[1]) em_cnt <= em_cnt + 1;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            if (bus.img_rd_en) rd_q.push_back(int'(bus.img_rd_addr));
            if (bus.pix_valid && bus.pix_ready) acc_q.push_back(int'(bus.pix_data));
            if (bus.fb_we) wr_q.push_back(int'({bus.fb_addr, bus.fb_wdata}));
            if (frame_done) done_cnt <= done_cnt + 1;
            if (prev_stall && bus.pix_valid) chk("pix_hold", bus.pix_data, prev_pix);
            prev_stall <= bus.pix_valid && !bus.pix_ready;
            prev_pix   <= bus.pix_data;
        end else begin
            prev_stall <= 1'b0;
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        start       = 1'b0;
        abort       = 1'b0;
        vsync_pulse = 1'b0;
        cyc_n++;
        bus.pix_ready = (ready_mode == 0) ? 1'b1 : ((cyc_n % 7 == 0) || (cyc_n % 7 == 2));
    endtask

    task automatic wait_writes(input int n, input string tag);
        int k = 0;
        while (wr_q.size() < n && k < 400) begin
            cyc();
            k++;
        end
        chk(tag, wr_q.size(), n);
    endtask

    task automatic check_frame(input string tag, input logic [7:0] thr, input logic back);
        chk({tag, "_nrd"}, rd_q.size(), NPIX);
        chk({tag, "_npix"}, acc_q.size(), NPIX);
        chk({tag, "_nwr"}, wr_q.size(), NPIX);
        for (int i = 0; i < NPIX; i++) begin
            if (i < rd_q.size())  chk({tag, "_rd_addr"}, rd_q[i], i);
            if (i < acc_q.size()) chk({tag, "_pix"}, acc_q[i], mem[i]);
            if (i < wr_q.size())
                chk({tag, "_fb"}, wr_q[i], (int'(back) << (AW + 1)) | (i << 1) | int'(mem[i] > thr));
        end
        rd_q.delete();
        acc_q.delete();
        wr_q.delete();
    endtask

    task automatic swap_check(input string tag);
        vsync_pulse = 1'b1;
        cyc();
        disp_m = !disp_m;
        fc_m++;
        swaps++;
        chk({tag, "_disp"}, disp_buf, disp_m);
        chk({tag, "_done"}, frame_done, 1);
        chk({tag, "_cnt"}, frame_count, fc_m);
    endtask

    task automatic new_image();
        for (int i = 0; i < NPIX; i++) mem[i] = 8'($urandom);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc_n);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] thr, thr_next;
        logic       back;
        int         sz, em_base, k;

        bus.pix_ready = 1'b1;
        new_image();
        #12;
        chk("rst_busy", busy, 0);
        chk("rst_disp", disp_buf, 0);
        chk("rst_cnt", frame_count, 0);
        chk("rst_rd_en", bus.img_rd_en, 0);
        chk("rst_pix_valid", bus.pix_valid, 0);
        chk("rst_fb_we", bus.fb_we, 0);
        chk("rst_fb_addr", bus.fb_addr, 0);
        chk("rst_thr", bus.sobel_threshold, 0);
        chk("rst_done", frame_done, 0);
        cyc();
        rst = 1'b0;
        repeat (2) cyc();

        // Single frame, Sobel always ready; mid-frame threshold change ignored.
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        back = !disp_m;
        start = 1'b1;
        cyc();
        chk("t1_busy", busy, 1);
        chk("t1_thr", bus.sobel_threshold, thr);
        threshold = ~thr;
        wait_writes(NPIX, "t1_wr");
        repeat (3) cyc();
        chk("t1_wait_busy", busy, 1);
        chk("t1_wait_disp", disp_buf, disp_m);
        check_frame("t1", thr, back);
        swap_check("t1");
        cyc();
        chk("t1_idle", busy, 0);
        chk("t1_pulse_once", frame_done, 0);
        chk("t1_done_cnt", done_cnt, swaps);

        // Backpressure pattern plus an early vsync that must be ignored.
        ready_mode = 1;
        new_image();
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        back = !disp_m;
        start = 1'b1;
        cyc();
        wait_writes(6, "t2_wr6");
        vsync_pulse = 1'b1;
        cyc();
        chk("t2_early_disp", disp_buf, disp_m);
        chk("t2_early_done", frame_done, 0);
        wait_writes(NPIX, "t2_wr");
        repeat (3) cyc();
        chk("t2_wait_busy", busy, 1);
        chk("t2_wait_disp", disp_buf, disp_m);
        check_frame("t2", thr, back);
        swap_check("t2");
        ready_mode = 0;
        cyc();

        // vsync coincident with the final result swaps on the next cycle.
        new_image();
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        back = !disp_m;
        em_base = em_cnt;
        start = 1'b1;
        cyc();
        wait_writes(4, "t3_wr4");
        vsync_pulse = 1'b1;
        cyc();
        chk("t3_early_disp", disp_buf, disp_m);
        k = 0;
        while (!(bus.edge_valid && (em_cnt - em_base == NPIX)) && k < 400) begin
            cyc();
            k++;
        end
        chk("t3_last_seen", em_cnt - em_base, NPIX);
        swap_check("t3");
        chk("t3_last_we", bus.fb_we, 1);
        cyc();
        check_frame("t3", thr, back);
        chk("t3_idle", busy, 0);

        // Continuous mode across three frames with per-frame thresholds.
        continuous = 1'b1;
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        start = 1'b1;
        cyc();
        for (int f = 0; f < 3; f++) begin
            back = !disp_m;
            wait_writes(4, "t4_wr4");
            thr_next = 8'($urandom_range(40, 200));
            threshold = thr_next;
            wait_writes(NPIX, "t4_wr");
            repeat (3) cyc();
            chk("t4_thr_hold", bus.sobel_threshold, thr);
            check_frame("t4", thr, back);
            if (f == 2) continuous = 1'b0;
            swap_check("t4");
            if (f < 2) begin
                chk("t4_thr_new", bus.sobel_threshold, thr_next);
                chk("t4_busy", busy, 1);
            end else begin
                chk("t4_idle", busy, 0);
            end
            thr = thr_next;
        end

        // Abort after five results; start+abort together; then a clean frame.
        new_image();
        threshold = 8'($urandom_range(40, 200));
        start = 1'b1;
        cyc();
        wait_writes(5, "t5_wr5");
        abort = 1'b1;
        cyc();
        chk("t5_busy", busy, 0);
        chk("t5_pix_valid", bus.pix_valid, 0);
        chk("t5_rd_en", bus.img_rd_en, 0);
        chk("t5_disp", disp_buf, disp_m);
        chk("t5_cnt", frame_count, fc_m);
        chk("t5_done", frame_done, 0);
        cyc();
        sz = wr_q.size();
        repeat (6) cyc();
        chk("t5_dropped", wr_q.size(), sz);
        vsync_pulse = 1'b1;
        cyc();
        chk("t5_no_swap", disp_buf, disp_m);
        start = 1'b1;
        abort = 1'b1;
        cyc();
        chk("t5_abort_beats_start", busy, 0);
        rd_q.delete();
        acc_q.delete();
        wr_q.delete();
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        back = !disp_m;
        start = 1'b1;
        cyc();
        wait_writes(NPIX, "t5_wr");
        repeat (2) cyc();
        check_frame("t5", thr, back);
        swap_check("t5");

        // Asynchronous reset mid-fetch, then a start while busy is ignored.
        cyc();
        threshold = 8'($urandom_range(40, 200));
        start = 1'b1;
        cyc();
        repeat (3) cyc();
        rst = 1'b1;
        #1;
        disp_m = 1'b0;
        fc_m = 0;
        chk("t6_busy", busy, 0);
        chk("t6_rd_en", bus.img_rd_en, 0);
        chk("t6_pix_valid", bus.pix_valid, 0);
        chk("t6_disp", disp_buf, 0);
        chk("t6_cnt", frame_count, 0);
        chk("t6_thr", bus.sobel_threshold, 0);
        chk("t6_fb_we", bus.fb_we, 0);
        cyc();
        rst = 1'b0;
        rd_q.delete();
        acc_q.delete();
        wr_q.delete();
        cyc();
        new_image();
        thr = 8'($urandom_range(40, 200));
        threshold = thr;
        back = !disp_m;
        start = 1'b1;
        cyc();
        repeat (2) cyc();
        start = 1'b1;
        cyc();
        wait_writes(NPIX, "t6_wr");
        repeat (2) cyc();
        check_frame("t6", thr, back);
        swap_check("t6");
        repeat (2) cyc();
        chk("done_total", done_cnt, swaps);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
